ccd_phase_monitor: RTL and testbench
====================================

# ccd_phase_monitor

Receiver and checker for the four-phase CCD clock protocol (phi_p, phi_l1, phi_l2, phi_r) produced by the on-chip CCD signal generator. The block samples the phase lines in the generator's clock domain, tracks the SHIFT / HOLD / PULSE frame sequence, and measures each frame: shift count, hold length and pulse width. It raises sticky error flags on protocol violations and sits beside the generator as a self-test and observability block, with results readable by the Wishbone glue.

## Interface
- EXP_SHIFTS, 2052: required number of complete shift quartets per frame
- MIN_P_WIDTH, 72: minimum legal PULSE length in cycles
- i_clk  in  1  phase clock; same clock that drives the generator
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  low synchronously clears state and counters; error flags are kept
- i_phi_p, i_phi_l1, i_phi_l2, i_phi_r  in  1 each  phase lines, synchronous to i_clk
- i_clr_err  in  1  one-cycle pulse that clears o_err
- o_frame_valid  out  1  one-cycle strobe; a frame's results are valid
- o_shift_count  out  14  quartets counted in the last frame; saturates at 16383
- o_hold_cycles  out  32  HOLD cycles in the last frame; saturates at all-ones
- o_p_width  out  16  PULSE cycles in the last frame; saturates
- o_err  out  4  sticky flags: [0] illegal code or sequence, [1] shift count mismatch, [2] pulse too short, [3] counter saturated
- o_state  out  2  current FSM state
- o_frame_count  out  16  completed frames, wraps (see Configuration)

## Operation
- Phase code is {p,l1,l2,r}, registered once before decode.
- Legal codes:
  - SETUP 1000
  - PULSE 1011
  - HOLD 0000
  - shift quartet Q0=0011, Q1=0010, Q2=0100, Q3=0100
- FSM states: SYNC=0, SHIFT=1, HOLD=2, PULSE=3.
- SYNC:
  - Any p=1 code (1000 or 1011) arms sync.
  - Armed and code 0011 -> SHIFT, sub-phase=1, counters cleared.
  - Any other code in SYNC sets no error.
- SHIFT:
  - A 2-bit sub-phase counter tracks Q0..Q3.
  - The code must match the expected quartet entry.
  - Q3 completion increments the shift count.
  - 0000 at sub-phase 0 -> HOLD, hold count=1.
  - 0011 at sub-phase 0 starts the next quartet.
  - Any other code: set err[0], go to SYNC.
- HOLD:
  - 0000 increments the hold count.
  - 1011 -> PULSE, p count=1.
  - Any other code: set err[0], go to SYNC.
- PULSE:
  - 1011 increments the p count.
  - 0011 ends the frame: latch results, pulse o_frame_valid, go to SHIFT with sub-phase=1 and counters restarted.
  - Any other code: set err[0], go to SYNC.
- Frame end checks:
  - shift count != EXP_SHIFTS sets err[1].
  - p count < MIN_P_WIDTH sets err[2].
  - Any counter saturation during the frame sets err[3].
- Error flags are sticky. A new error in the same cycle as i_clr_err wins: that bit stays set.
- A frame aborted into SYNC produces no o_frame_valid and leaves the previous results unchanged.

## Timing
- Reset values: all outputs 0, state SYNC, sync unarmed.
- Latency: phase code at input cycle N -> FSM update at edge N+1 -> o_frame_valid high after edge N+2, for exactly one cycle.
- Result outputs update only together with o_frame_valid and are stable between strobes.
- i_enable low takes effect at the next edge: state SYNC, sync unarmed, all counters 0. o_err and the last results are held.
- Reset asserted mid-frame clears asynchronously. Nothing is reported for the partial frame.
- Back-to-back frames are supported with no dead cycle: the terminating 0011 is also Q0 of the next frame.

## Configuration
- CCD_MON_FRAME_CNT_EN defined: o_frame_count increments on every o_frame_valid and wraps 65535 -> 0. It is cleared by reset and by i_enable low.
- Not defined: no frame counter is built and o_frame_count is tied to 0.

## Structure
- Shared package:
  - phase code constants (SETUP, PULSE, HOLD, Q0..Q3)
  - FSM state encoding
  - error bit indices
- The generator uses the same code constants.
- One sub-module, ccd_quartet_decoder: the sub-phase counter plus the expected-code match. It outputs quartet_done and seq_err.

## Test plan
- Drive an ideal frame (1000 x20, 2052 quartets, 0000 x4106, 1011 x73, 0011) -> one o_frame_valid; shift=2052, hold=4106, p_width=73; o_err=0.
- Same frame but 2051 quartets -> o_frame_valid with shift=2051 and err[1]=1; err[1] persists until i_clr_err.
- Ideal frame with only 40 PULSE cycles -> p_width=40 and err[2]=1.
- Inject 0110 mid-quartet -> err[0]=1, state SYNC, no strobe. Resync on 1000 then 0011, and the next full frame is reported.
- i_clr_err in the same cycle that err[0] is raised -> err[0] stays 1. Assert i_rst_n mid-HOLD -> all outputs 0 immediately.
- With CCD_MON_FRAME_CNT_EN, run three ideal frames -> o_frame_count=3. Without the macro -> o_frame_count stays 0.

Source files
------------

// File: rtl/ccd_phase_monitor_pkg.sv
// Shared definitions for the CCD four-phase clock protocol: phase codes, monitor FSM
// encoding, error flag indices and the frame result payload.
package ccd_phase_monitor_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned SUB_W   = 2;
    localparam int unsigned SHIFT_W = 14;
    localparam int unsigned HOLD_W  = 32;
    localparam int unsigned PW_W    = 16;
    localparam int unsigned FCNT_W  = 16;
    localparam int unsigned ERR_W   = 4;

    // Phase code layout is {p, l1, l2, r}
    localparam logic [CODE_W-1:0] CODE_SETUP = 4'b1000;
    localparam logic [CODE_W-1:0] CODE_PULSE = 4'b1011;
    localparam logic [CODE_W-1:0] CODE_HOLD  = 4'b0000;
    localparam logic [CODE_W-1:0] CODE_Q0    = 4'b0011;
    localparam logic [CODE_W-1:0] CODE_Q1    = 4'b0010;
    localparam logic [CODE_W-1:0] CODE_Q2    = 4'b0100;
    localparam logic [CODE_W-1:0] CODE_Q3    = 4'b0100;

    localparam int unsigned ERR_SEQ    = 0;
    localparam int unsigned ERR_SHIFT  = 1;
    localparam int unsigned ERR_PWIDTH = 2;
    localparam int unsigned ERR_SAT    = 3;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PULSE = 2'd3
    } state_e;

    typedef struct packed {
        logic [SHIFT_W-1:0] shift_count;
        logic [HOLD_W-1:0]  hold_cycles;
        logic [PW_W-1:0]    p_width;
    } frame_res_t;

    function automatic logic [CODE_W-1:0] quartet_code(input logic [SUB_W-1:0] idx);
        logic [CODE_W-1:0] code;
        case (idx)
            2'd0:    code = CODE_Q0;
            2'd1:    code = CODE_Q1;
            2'd2:    code = CODE_Q2;
            default: code = CODE_Q3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ccd_quartet_decoder.sv
// Shift-quartet sub-phase tracker: compares each code against the expected quartet
// entry and flags quartet completion or a sequence violation.
module ccd_quartet_decoder
    import ccd_phase_monitor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CODE_W-1:0] code,
    input  logic              active,
    input  logic              load,
    output logic              quartet_done_c,
    output logic              seq_err_c,
    output logic              at_boundary_c
);

    logic [SUB_W-1:0] sub_q, sub_d;
    logic             match_c;

    // HOLD is only a legal exit between quartets, never mid-quartet
    always_comb begin
        match_c        = (code == quartet_code(sub_q));
        at_boundary_c  = (sub_q == 2'd0);
        quartet_done_c = active && match_c && (sub_q == 2'd3);
        seq_err_c      = active && !match_c && !(at_boundary_c && (code == CODE_HOLD));
        sub_d          = sub_q;
        if (!enable) begin
            sub_d = '0;
        end else if (load) begin
            sub_d = 2'd1;
        end else if (active && match_c) begin
            sub_d = sub_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= '0;
        end else begin
            sub_q <= sub_d;
        end
    end

endmodule

// File: rtl/ccd_phase_monitor.sv
// CCD phase protocol monitor: tracks SHIFT/HOLD/PULSE frames, measures them and
// keeps sticky error flags. Define CCD_MON_FRAME_CNT_EN to build the frame counter.
module ccd_phase_monitor
    import ccd_phase_monitor_pkg::*;
#(
    parameter int unsigned EXP_SHIFTS  = 2052,
    parameter int unsigned MIN_P_WIDTH = 72
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_phi_p,
    input  logic               i_phi_l1,
    input  logic               i_phi_l2,
    input  logic               i_phi_r,
    input  logic               i_clr_err,
    output logic               o_frame_valid,
    output logic [SHIFT_W-1:0] o_shift_count,
    output logic [HOLD_W-1:0]  o_hold_cycles,
    output logic [PW_W-1:0]    o_p_width,
    output logic [ERR_W-1:0]   o_err,
    output logic [1:0]         o_state,
    output logic [FCNT_W-1:0]  o_frame_count
);

    logic [CODE_W-1:0]  code_q, code_d;
    state_e             state_q, state_d;
    logic               armed_q, armed_d;
    logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PW_W-1:0]    p_cnt_q, p_cnt_d;
    logic               sat_q, sat_d;
    logic               end_q, end_d;
    frame_res_t         snap_q, snap_d;
    logic [ERR_W-1:0]   err_set_q, err_set_d;
    logic               frame_valid_q, frame_valid_d;
    frame_res_t         res_q, res_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               dec_active, dec_load;
    logic               quartet_done_c, seq_err_c, at_boundary_c;

    ccd_quartet_decoder u_quartet_decoder (
        .clk            (i_clk),
        .rst_n          (i_rst_n),
        .enable         (i_enable),
        .code           (code_q),
        .active         (dec_active),
        .load           (dec_load),
        .quartet_done_c (quartet_done_c),
        .seq_err_c      (seq_err_c),
        .at_boundary_c  (at_boundary_c)
    );

    always_comb code_d = {i_phi_p, i_phi_l1, i_phi_l2, i_phi_r};

    // Frame FSM; the frame-ending 0011 also serves as Q0 of the following frame
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        shift_cnt_d = shift_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        p_cnt_d     = p_cnt_q;
        sat_d       = sat_q;
        end_d       = 1'b0;
        snap_d      = snap_q;
        err_set_d   = '0;
        dec_active  = 1'b0;
        dec_load    = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (code_q[CODE_W-1]) armed_d = 1'b1;
                if (armed_q && (code_q == CODE_Q0)) begin
                    state_d     = ST_SHIFT;
                    armed_d     = 1'b0;
                    dec_load    = 1'b1;
                    shift_cnt_d = '0;
                    hold_cnt_d  = '0;
                    p_cnt_d     = '0;
                    sat_d       = 1'b0;
                end
            end
            ST_SHIFT: begin
                dec_active = 1'b1;
                if (seq_err_c) begin
                    state_d            = ST_SYNC;
                    err_set_d[ERR_SEQ] = 1'b1;
                end else if (quartet_done_c) begin
                    if (shift_cnt_q == '1) sat_d = 1'b1;
                    else                   shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
                end else if (at_boundary_c && (code_q == CODE_HOLD)) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            ST_HOLD: begin
                if (code_q == CODE_HOLD) begin
                    if (hold_cnt_q == '1) sat_d = 1'b1;
                    else                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (code_q == CODE_PULSE) begin
                    state_d = ST_PULSE;
                    p_cnt_d = PW_W'(1);
                end else begin
                    state_d            = ST_SYNC;
                    err_set_d[ERR_SEQ] = 1'b1;
                end
            end
            ST_PULSE: begin
                if (code_q == CODE_PULSE) begin
                    if (p_cnt_q == '1) sat_d = 1'b1;
                    else               p_cnt_d = p_cnt_q + PW_W'(1);
                end else if (code_q == CODE_Q0) begin
                    end_d                 = 1'b1;
                    snap_d.shift_count    = shift_cnt_q;
                    snap_d.hold_cycles    = hold_cnt_q;
                    snap_d.p_width        = p_cnt_q;
                    err_set_d[ERR_SHIFT]  = (shift_cnt_q != SHIFT_W'(EXP_SHIFTS));
                    err_set_d[ERR_PWIDTH] = (p_cnt_q < PW_W'(MIN_P_WIDTH));
                    err_set_d[ERR_SAT]    = sat_q;
                    state_d               = ST_SHIFT;
                    dec_load              = 1'b1;
                    shift_cnt_d           = '0;
                    hold_cnt_d            = '0;
                    p_cnt_d               = '0;
                    sat_d                 = 1'b0;
                end else begin
                    state_d            = ST_SYNC;
                    err_set_d[ERR_SEQ] = 1'b1;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (!i_enable) begin
            state_d     = ST_SYNC;
            armed_d     = 1'b0;
            shift_cnt_d = '0;
            hold_cnt_d  = '0;
            p_cnt_d     = '0;
            sat_d       = 1'b0;
            end_d       = 1'b0;
            err_set_d   = '0;
        end
    end

    // Result stage: a flag raised in the same cycle as i_clr_err survives the clear
    always_comb begin
        frame_valid_d = end_q;
        res_d         = end_q ? snap_q : res_q;
        err_d         = (err_q & ~{ERR_W{i_clr_err}}) | err_set_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q        <= '0;
            state_q       <= ST_SYNC;
            armed_q       <= 1'b0;
            shift_cnt_q   <= '0;
            hold_cnt_q    <= '0;
            p_cnt_q       <= '0;
            sat_q         <= 1'b0;
            end_q         <= 1'b0;
            snap_q        <= '0;
            err_set_q     <= '0;
            frame_valid_q <= 1'b0;
            res_q         <= '0;
            err_q         <= '0;
        end else begin
            code_q        <= code_d;
            state_q       <= state_d;
            armed_q       <= armed_d;
            shift_cnt_q   <= shift_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            p_cnt_q       <= p_cnt_d;
            sat_q         <= sat_d;
            end_q         <= end_d;
            snap_q        <= snap_d;
            err_set_q     <= err_set_d;
            frame_valid_q <= frame_valid_d;
            res_q         <= res_d;
            err_q         <= err_d;
        end
    end

`ifdef CCD_MON_FRAME_CNT_EN
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!i_enable)  frame_cnt_d = '0;
        else if (end_q) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign o_frame_count = frame_cnt_q;
`else
    assign o_frame_count = '0;
`endif

    assign o_frame_valid = frame_valid_q;
    assign o_shift_count = res_q.shift_count;
    assign o_hold_cycles = res_q.hold_cycles;
    assign o_p_width     = res_q.p_width;
    assign o_err         = err_q;
    assign o_state       = 2'(state_q);

endmodule

// File: tb/tb_ccd_phase_monitor.sv
// Scoreboard bench for ccd_phase_monitor: directed frames push expected results,
// a monitor pops and compares them on every o_frame_valid strobe.
module tb_ccd_phase_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        phi_p, phi_l1, phi_l2, phi_r;
    logic        clr;
    logic        o_frame_valid;
    logic [13:0] o_shift_count;
    logic [31:0] o_hold_cycles;
    logic [15:0] o_p_width;
    logic [3:0]  o_err;
    logic [1:0]  o_state;
    logic [15:0] o_frame_count;

    typedef struct {
        logic [13:0] sh;
        logic [31:0] hd;
        logic [15:0] pw;
        logic [3:0]  er;
        logic [15:0] fc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobe = 0;
    logic [3:0]  exp_err  = 4'b0000;
    logic [15:0] exp_fc   = 16'd0;
    logic [13:0] last_sh  = 14'd0;

    always #5 clk = ~clk;

    ccd_phase_monitor dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (en),
        .i_phi_p       (phi_p),
        .i_phi_l1      (phi_l1),
        .i_phi_l2      (phi_l2),
        .i_phi_r       (phi_r),
        .i_clr_err     (clr),
        .o_frame_valid (o_frame_valid),
        .o_shift_count (o_shift_count),
        .o_hold_cycles (o_hold_cycles),
        .o_p_width     (o_p_width),
        .o_err         (o_err),
        .o_state       (o_state),
        .o_frame_count (o_frame_count)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_frame_valid) begin
            n_strobe++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe, expected none");
            end else begin
                e = sb_q.pop_front();
                check("shift_count", 64'(o_shift_count), 64'(e.sh));
                check("hold_cycles", 64'(o_hold_cycles), 64'(e.hd));
                check("p_width",     64'(o_p_width),     64'(e.pw));
                check("err_at_frame", 64'(o_err),        64'(e.er));
                check("frame_count", 64'(o_frame_count), 64'(e.fc));
            end
        end
    end

    task automatic step(input logic [3:0] c);
        {phi_p, phi_l1, phi_l2, phi_r} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_start(input int n);
        repeat (n) step(4'b1000);
        step(4'b0011);
    endtask

    // Assumes Q0 of the first quartet has already been driven
    task automatic body(input int nq, input int nh, input int np, input bit term);
        exp_t       e;
        logic [3:0] bits;
        step(4'b0010); step(4'b0100); step(4'b0100);
        for (int i = 1; i < nq; i++) begin
            step(4'b0011); step(4'b0010); step(4'b0100); step(4'b0100);
        end
        repeat (nh) step(4'b0000);
        repeat (np) step(4'b1011);
        if (term) begin
            bits    = 4'b0000;
            bits[1] = (nq != 2052);
            bits[2] = (np < 72);
            exp_err = exp_err | bits;
`ifdef CCD_MON_FRAME_CNT_EN
            exp_fc  = exp_fc + 16'd1;
`endif
            e.sh = 14'(nq); e.hd = 32'(nh); e.pw = 16'(np); e.er = exp_err; e.fc = exp_fc;
            sb_q.push_back(e);
            last_sh = 14'(nq);
            step(4'b0011);
        end
    endtask

    // Finish the open quartet, then disable the block; optionally clear errors
    task automatic park(input bit do_clr);
        step(4'b0010); step(4'b0100); step(4'b0100);
        en = 1'b0;
        repeat (3) step(4'b0000);
        exp_fc = 16'd0;
        check("state_after_disable", 64'(o_state), 64'd0);
        check("results_held", 64'(o_shift_count), 64'(last_sh));
        check("err_sticky", 64'(o_err), 64'(exp_err));
        if (do_clr) begin
            clr = 1'b1;
            step(4'b0000);
            clr = 1'b0;
            exp_err = 4'b0000;
            step(4'b0000);
            check("err_cleared", 64'(o_err), 64'd0);
        end
    endtask

    initial begin
        int strobe_before;
        int wait_cycles;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        {phi_p, phi_l1, phi_l2, phi_r} = 4'b0000;
        #12;
        check("rst_state",       64'(o_state),       64'd0);
        check("rst_err",         64'(o_err),         64'd0);
        check("rst_valid",       64'(o_frame_valid), 64'd0);
        check("rst_shift",       64'(o_shift_count), 64'd0);
        check("rst_frame_count", 64'(o_frame_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ideal frame, then a back-to-back frame one quartet short
        en = 1'b1;
        sync_start(20);
        body(2052, 4106, 73, 1'b1);
        body(2051, 4, 73, 1'b1);
        park(1'b1);

        // Short PULSE
        en = 1'b1;
        sync_start(5);
        body(2052, 4, 40, 1'b1);
        park(1'b1);

        // Illegal code mid-quartet with a simultaneous clear, then resync
        en = 1'b1;
        sync_start(3);
        step(4'b0010);
        strobe_before = n_strobe;
        step(4'b0110);
        step(4'b1000);
        clr = 1'b1;
        step(4'b1000);
        clr = 1'b0;
        exp_err = 4'b0001;
        check("seq_err_wins_clear", 64'(o_err), 64'd1);
        check("state_sync_after_err", 64'(o_state), 64'd0);
        check("no_strobe_on_abort", 64'(n_strobe), 64'(strobe_before));
        sync_start(2);
        body(2052, 4, 73, 1'b1);
        park(1'b0);

        // Asynchronous reset while in HOLD
        en = 1'b1;
        sync_start(2);
        body(3, 6, 0, 1'b0);
        check("state_hold", 64'(o_state), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 64'(o_state),       64'd0);
        check("arst_err",   64'(o_err),         64'd0);
        check("arst_shift", 64'(o_shift_count), 64'd0);
        check("arst_hold",  64'(o_hold_cycles), 64'd0);
        check("arst_pw",    64'(o_p_width),     64'd0);
        exp_err = 4'b0000;
        exp_fc  = 16'd0;
        last_sh = 14'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back ideal frames, one at the exact minimum pulse width
        sync_start(4);
        body(2052, 4, 73, 1'b1);
        body(2052, 4, 72, 1'b1);
        body(2052, 4, 73, 1'b1);
        step(4'b0010); step(4'b0100); step(4'b0100);
`ifdef CCD_MON_FRAME_CNT_EN
        check("final_frame_count", 64'(o_frame_count), 64'd3);
`else
        check("final_frame_count", 64'(o_frame_count), 64'd0);
`endif
        check("final_err", 64'(o_err), 64'd0);
        en = 1'b0;
        wait_cycles = 0;
        while (sb_q.size() != 0 && wait_cycles < 10) begin
            step(4'b0000);
            wait_cycles++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
